// File: rtl/reg_dump_reader_if.sv
// Bundle of the register-file read port, the dump stream port and the
// control/status lines of reg_dump_reader.
interface reg_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;

  logic [ADDR_W-1:0] rg_rd_addr1;
  logic [ADDR_W-1:0] rg_rd_addr2;
  logic [DATA_W-1:0] rg_rd_data1;
  logic [DATA_W-1:0] rg_rd_data2;

  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, first_addr, last_addr,
    input  rg_rd_data1, rg_rd_data2,
    input  dump_ready,
    output rg_rd_addr1, rg_rd_addr2,
    output dump_valid, dump_addr, dump_data, dump_last,
    output busy, done, err
  );

  modport master (
    output start, first_addr, last_addr,
    output rg_rd_data1, rg_rd_data2,
    output dump_ready,
    input  rg_rd_addr1, rg_rd_addr2,
    input  dump_valid, dump_addr, dump_data, dump_last,
    input  busy, done, err
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Streams a contiguous register range as (addr, data) beats. Two registers are
// fetched per FETCH cycle; the dump_data flop holds entry 0, buf1 holds entry 1.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  reg_dump_reader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND0,
    S_SEND1,
    S_DONE
  } state_t;

  state_t            state_q, state_d;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              b1v_q, b1v_d;

  logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;
  logic              dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_last_q, dump_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic              range_ok;
  logic              pair_end;
  logic [ADDR_W:0]   ptr_inc;
  logic [ADDR_W:0]   last_ext;
  logic [ADDR_W-1:0] ptr_p1;
  logic [ADDR_W-1:0] ptr_p2;
  logic [ADDR_W-1:0] ptr_p3;

  assign hs       = dump_valid_q & bus.dump_ready;
  assign range_ok = (bus.first_addr <= bus.last_addr);
  // One extra bit keeps ptr=31 from wrapping to 0 when testing ptr+1 <= last.
  assign ptr_inc  = {1'b0, ptr_q} + (ADDR_W + 1)'(1);
  assign last_ext = {1'b0, last_q};
  assign pair_end = (ptr_inc == last_ext);
  assign ptr_p1   = ptr_q + ADDR_W'(1);
  assign ptr_p2   = ptr_q + ADDR_W'(2);
  assign ptr_p3   = ptr_q + ADDR_W'(3);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default before the case so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start && range_ok) state_d = S_FETCH;
      S_FETCH: state_d = S_SEND0;
      S_SEND0: if (hs) state_d = b1v_q ? S_SEND1 : S_DONE;
      S_SEND1: if (hs) state_d = pair_end ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; everything leaves through a flop.
  always_comb begin
    ptr_d        = ptr_q;
    last_d       = last_q;
    buf1_d       = buf1_q;
    b1v_d        = b1v_q;
    rd_addr1_d   = rd_addr1_q;
    rd_addr2_d   = rd_addr2_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;
    err_d        = 1'b0;
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (range_ok) begin
            last_d     = bus.last_addr;
            ptr_d      = bus.first_addr;
            rd_addr1_d = bus.first_addr;
            rd_addr2_d = bus.first_addr + ADDR_W'(1);
            b1v_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        buf1_d       = bus.rg_rd_data2;
        b1v_d        = (ptr_inc <= last_ext);
        dump_valid_d = 1'b1;
        dump_addr_d  = ptr_q;
        dump_data_d  = bus.rg_rd_data1;
        dump_last_d  = (ptr_q == last_q);
      end

      S_SEND0: begin
        if (hs) begin
          if (b1v_q) begin
            dump_addr_d = ptr_p1;
            dump_data_d = buf1_q;
            dump_last_d = pair_end;
          end else begin
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
          end
        end
      end

      S_SEND1: begin
        if (hs) begin
          dump_valid_d = 1'b0;
          dump_last_d  = 1'b0;
          if (!pair_end) begin
            ptr_d      = ptr_p2;
            rd_addr1_d = ptr_p2;
            rd_addr2_d = ptr_p3;
          end
        end
      end

      S_DONE:  ;
      default: ;
    endcase
  end

  // NOTE: the two-entry buffer is a handful of flops, not a RAM, so it is reset
  // along with everything else and no stale beat survives a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      last_q       <= '0;
      buf1_q       <= '0;
      b1v_q        <= 1'b0;
      rd_addr1_q   <= '0;
      rd_addr2_q   <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      last_q       <= last_d;
      buf1_q       <= buf1_d;
      b1v_q        <= b1v_d;
      rd_addr1_q   <= rd_addr1_d;
      rd_addr2_q   <= rd_addr2_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.rg_rd_addr1 = rd_addr1_q;
  assign bus.rg_rd_addr2 = rd_addr2_q;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_addr   = dump_addr_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.dump_last   = dump_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: a register-file model feeds the read
// ports and a scoreboard queue holds the beats each dump must produce.
module tb_reg_dump_reader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_dump_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] regs [32];
  assign bus.rg_rd_data1 = regs[bus.rg_rd_addr1];
  assign bus.rg_rd_data2 = regs[bus.rg_rd_addr2];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t sb [$];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int start_cyc;
  int first_valid_cyc;
  int last_hs_cyc;
  int beat_count;
  bit first_seen;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Handshake monitor: pops the scoreboard and checks that stalled beats hold.
  bit                prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", bus.dump_valid, 1'b1);
        check("hold_addr",  bus.dump_addr,  prev_addr);
        check("hold_data",  bus.dump_data,  prev_data);
        check("hold_last",  bus.dump_last,  prev_last);
      end
      if (bus.dump_valid && !first_seen) begin
        first_seen      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (bus.dump_valid && bus.dump_ready) begin
        check("beat_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          beat_t b;
          b = sb.pop_front();
          check("beat_addr", bus.dump_addr, b.addr);
          check("beat_data", bus.dump_data, b.data);
          check("beat_last", bus.dump_last, b.last);
        end
        beat_count++;
        last_hs_cyc = cyc + 1;
      end
      prev_hold = bus.dump_valid && !bus.dump_ready;
      prev_addr = bus.dump_addr;
      prev_data = bus.dump_data;
      prev_last = bus.dump_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    beat_t b;
    bus.start      = 1'b1;
    bus.first_addr = f;
    bus.last_addr  = l;
    first_seen     = 1'b0;
    beat_count     = 0;
    for (int a = int'(f); a <= int'(l); a++) begin
      b.addr = a[ADDR_W-1:0];
      b.data = regs[a];
      b.last = (a == int'(l));
      sb.push_back(b);
    end
    tick();
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output int done_cyc);
    bit got = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (bus.done) begin
        got      = 1'b1;
        done_cyc = cyc;
      end
    end
    check("done_within_budget", got, 1'b1);
  endtask

  task automatic check_idle_after();
    tick();
    check("idle_done",  bus.done,       1'b0);
    check("idle_busy",  bus.busy,       1'b0);
    check("idle_valid", bus.dump_valid, 1'b0);
    check("sb_drained", sb.size(),      0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, bus.dump_valid,  1'b0);
    check({tag, "_last"},  bus.dump_last,   1'b0);
    check({tag, "_done"},  bus.done,        1'b0);
    check({tag, "_err"},   bus.err,         1'b0);
    check({tag, "_busy"},  bus.busy,        1'b0);
    check({tag, "_addr"},  bus.dump_addr,   0);
    check({tag, "_data"},  bus.dump_data,   0);
    check({tag, "_rd1"},   bus.rg_rd_addr1, 0);
    check({tag, "_rd2"},   bus.rg_rd_addr2, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dc;
    bit  got;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    bus.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hC0DE_0000 | i;
    regs[5] = 32'hDEAD_BEEF;
    regs[6] = 32'h1234_5678;

    repeat (2) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Two-register dump with the consumer always ready.
    bus.dump_ready = 1'b1;
    do_start(5'd5, 5'd6);
    check("t1_busy", bus.busy, 1'b1);
    check("t1_no_valid_in_fetch", bus.dump_valid, 1'b0);
    wait_done(20, dc);
    // Valid is registered out of FETCH, so the consumer first sees it at N+2.
    check("t1_first_valid_latency", first_valid_cyc, start_cyc + 1);
    check("t1_done_after_last_hs", dc, last_hs_cyc);
    check("t1_beats", beat_count, 2);
    check_idle_after();

    // Full range: 16 fetch groups of 3 cycles, 48 cycles counting the first beat.
    do_start(5'd0, 5'd31);
    wait_done(80, dc);
    check("t2_first_beat_to_done", dc - first_valid_cyc, 47);
    check("t2_beats", beat_count, 32);
    check_idle_after();

    // Single-register ranges, including the top register.
    do_start(5'd3, 5'd3);
    wait_done(20, dc);
    check("t3_beats", beat_count, 1);
    check_idle_after();
    do_start(5'd31, 5'd31);
    wait_done(20, dc);
    check("t3b_beats", beat_count, 1);
    check_idle_after();

    // Inverted range is rejected with a one-cycle err.
    do_start(5'd10, 5'd4);
    check("t4_err", bus.err, 1'b1);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_valid", bus.dump_valid, 1'b0);
    tick();
    check("t4_err_pulse", bus.err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_quiet_valid", bus.dump_valid, 1'b0);
      check("t4_quiet_busy",  bus.busy,       1'b0);
    end

    // Backpressure on the x7 beat; writes after FETCH must not leak into beats.
    bus.dump_ready = 1'b0;
    do_start(5'd7, 5'd8);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = bus.dump_valid;
    end
    check("t5_valid_seen", got, 1'b1);
    regs[7] = 32'hBAD0_0007;
    regs[8] = 32'hBAD0_0008;
    repeat (5) tick();
    check("t5_no_hs_while_stalled", beat_count, 0);
    bus.dump_ready = 1'b1;
    wait_done(20, dc);
    check("t5_beats", beat_count, 2);
    check_idle_after();

    // Random consumer stalls over a mid-file range.
    do_start(5'd12, 5'd20);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      bus.dump_ready = 1'($urandom_range(0, 1));
      tick();
      got = bus.done;
    end
    check("t6_done_within_budget", got, 1'b1);
    check("t6_beats", beat_count, 9);
    bus.dump_ready = 1'b1;
    check_idle_after();

    // Asynchronous reset after three beats, then a clean fresh dump.
    do_start(5'd0, 5'd31);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = (beat_count >= 3);
    end
    check("t7_three_beats", got, 1'b1);
    #2 reset = 1'b1;
    #1 check_all_zero("midreset");
    sb.delete();
    tick();
    reset = 1'b0;
    tick();
    check("t7_post_reset_busy",  bus.busy,       1'b0);
    check("t7_post_reset_valid", bus.dump_valid, 1'b0);
    do_start(5'd20, 5'd22);
    wait_done(20, dc);
    check("t7_beats", beat_count, 3);
    check_idle_after();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
